mod_n_toggle_counter: RTL and testbench

Synchronous, programmable modulo-N up/down counter that produces the toggle-enable for the toggle flip-flop stage directly downstream of it. It also contains that toggle stage, giving a divided square-wave output and its complement. The block is the standard front end for frequency division and event-count chains. Its terminal-count pulse is the T input of the following toggle stage.

---
 rtl/mod_n_toggle_counter.sv | 90 +++++++++
 tb/tb_mod_n_toggle_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mod_n_toggle_counter.sv
// rtl/mod_n_toggle_counter.sv - programmable modulo-N up/down counter with toggle divider stage
//
// Purpose:
//   Counts 0..modulus (modulus+1 states) up or down. It raises a terminal-count
//   pulse (tc) on the wrap cycle. tc drives an internal toggle stage, which gives
//   a divided square wave (div_out) and a separately registered complement
//   (div_outb). With en held high the div_out period is 2*(modulus+1) clocks.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   count enable (hold when 0)
//   up        in   direction, 1 = up, 0 = down
//   load      in   synchronous load strobe, priority over en
//   load_val  in   load value, clamped to modulus
//   modulus   in   maximum count M
//   count     out  registered count
//   tc        out  combinational terminal-count pulse (toggle-stage T input)
//   div_out   out  toggle-stage output
//   div_outb  out  registered complement of div_out

module mod_n_toggle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             div_out,
  output logic             div_outb
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             div_q, div_d;
  logic             divb_q, divb_d;
  logic             oor;
  logic             term;
  logic             tc_int;

  always_comb begin
    // A count above the modulus can only occur after the modulus is lowered
    // mid-count. It suppresses tc and snaps the count back to 0.
    oor    = (count_q > modulus);
    term   = up ? (count_q == modulus) : (count_q == '0);
    tc_int = rst & en & ~load & term & ~oor;

    count_d = count_q;
    div_d   = div_q;
    divb_d  = divb_q;

    if (load) begin
      count_d = (load_val > modulus) ? modulus : load_val;
    end else if (en) begin
      // Wrap is done by compare, never by natural overflow, so any modulus works.
      if (oor) begin
        count_d = '0;
      end else if (up) begin
        count_d = term ? '0 : count_q + WIDTH'(1);
      end else begin
        count_d = term ? modulus : count_q - WIDTH'(1);
      end
      div_d  = div_q ^ tc_int;
      // Complement comes from its own flop so both outputs switch on the same edge.
      divb_d = ~(div_q ^ tc_int);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      div_q   <= 1'b0;
      divb_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      divb_q  <= divb_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_int;
  assign div_out  = div_q;
  assign div_outb = divb_q;

endmodule

// File: tb/tb_mod_n_toggle_counter.sv
// tb/tb_mod_n_toggle_counter.sv - scoreboard bench for mod_n_toggle_counter
module tb_mod_n_toggle_counter;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] modulus;
  logic [W-1:0] count;
  logic         tc;
  logic         div_out;
  logic         div_outb;

  mod_n_toggle_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .modulus(modulus),
    .count(count), .tc(tc), .div_out(div_out), .div_outb(div_outb)
  );

  typedef struct {
    int cnt;
    bit tcv;
    bit dv;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_count = 0;
  bit   m_div = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: behaviour from the plain arithmetic rules, one call per clock.
  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input int md);
    exp_t x;
    bit   is_t;
    bit   etc;
    rst = r; en = e; up = u; load = l;
    load_val = W'(lv); modulus = W'(md);
    if (!r) begin
      m_count = 0;
      m_div   = 0;
    end
    is_t = u ? (m_count == md) : (m_count == 0);
    etc  = r && e && !l && (m_count <= md) && is_t;
    x.cnt = m_count; x.tcv = etc; x.dv = m_div;
    exp_q.push_back(x);
    if (r) begin
      if (l) m_count = (lv > md) ? md : lv;
      else if (e) begin
        if (m_count > md) m_count = 0;
        else if (u)       m_count = (m_count + 1) % (md + 1);
        else              m_count = (m_count + md) % (md + 1);
        m_div = m_div ^ etc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count", int'(count), x.cnt);
        chk("tc", int'(tc), int'(x.tcv));
        chk("div_out", int'(div_out), int'(x.dv));
        chk("div_outb", int'(div_outb), int'(!x.dv));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int md;
    bit u;
    rst = 0; en = 0; up = 1; load = 0; load_val = '0; modulus = 4'd5;
    @(posedge clk);
    #1;
    step(0, 1, 1, 0, 0, 5);
    step(0, 1, 1, 0, 0, 5);

    // Up count M=5; 8 edges leave div_out high
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 5);
    step(1, 0, 1, 1, 5, 9);

    // Asynchronous reset mid-count, observed between edges
    chk("pre_reset_count", int'(count), m_count);
    #2;
    rst = 0; en = 1; up = 0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tc", int'(tc), 0);
    chk("async_div", int'(div_out), 0);
    chk("async_divb", int'(div_outb), 1);
    step(0, 1, 0, 0, 0, 5);

    // Down count M=5 with an enable pause
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 5);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 5);

    // Loads: plain, clamped, and colliding with the terminal count
    step(1, 1, 1, 1, 3, 5);
    step(1, 1, 1, 1, 12, 9);
    step(1, 1, 1, 1, 2, 9);
    step(1, 1, 1, 0, 0, 9);

    // Modulus lowered below current count
    step(1, 0, 1, 1, 8, 9);
    step(1, 1, 1, 0, 0, 4);
    step(1, 1, 1, 0, 0, 4);

    // M=0: divide-by-2 of the enabled clock
    for (int i = 0; i < 5; i++) step(1, 1, i[0], 0, 0, 0);

    // Full range M=15, both wrap directions
    step(1, 0, 1, 1, 15, 15);
    step(1, 1, 1, 0, 0, 15);
    step(1, 1, 0, 0, 0, 15);
    step(1, 1, 0, 0, 0, 15);

    // Randomized traffic
    md = 7; u = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) md = $urandom_range(0, (1 << W) - 1);
      if ($urandom_range(0, 19) == 0) u = ~u;
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 9) < 8),
           u,
           ($urandom_range(0, 19) == 0),
           $urandom_range(0, (1 << W) - 1),
           md);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
